// File: rtl/eth_arp_tx.sv
// eth_arp_tx: ARP reply transmitter for the TX path.
// On an arbiter grant (i_arp_sync) the requester and self MAC/IP are latched and a
// complete, zero-padded Ethernet/ARP reply is streamed as big-endian 32-bit words.
// The TX MAC appends the FCS. o_arp_ready is high while idle; its rising edge tells
// the arbiter that the frame has been handed off.
//
// Optional build macro: ARP_TX_GRATUITOUS_EN adds i_grat_req, which starts a
// gratuitous ARP request (broadcast, oper=1, THA=0, TPA=self IP) from idle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_arp_sync      one-cycle grant pulse (reply)
//   i_grat_req      gratuitous request pulse (only with ARP_TX_GRATUITOUS_EN)
//   i_self_mac/ip   own addresses
//   i_req_mac/ip    requester addresses (target of the reply)
//   o_arp_ready     1 = idle; rising edge = frame done
//   o_out_*         word stream (data/sop/eop/vld/empty), i_out_rdy = sink ready
module eth_arp_tx #(
   parameter int FRAME_WORDS = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_arp_sync,
`ifdef ARP_TX_GRATUITOUS_EN
   input  logic        i_grat_req,
`endif
   input  logic [47:0] i_self_mac,
   input  logic [31:0] i_self_ip,
   input  logic [47:0] i_req_mac,
   input  logic [31:0] i_req_ip,
   output logic        o_arp_ready,
   output logic [31:0] o_out_data,
   output logic        o_out_sop,
   output logic        o_out_eop,
   output logic        o_out_vld,
   output logic [1:0]  o_out_empty,
   input  logic        i_out_rdy
);

   localparam logic [4:0] LastIdx = 5'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e      r_state;
   logic [4:0]  r_cnt;
   logic [47:0] r_dst_mac;
   logic [47:0] r_src_mac;
   logic [31:0] r_src_ip;
   logic [31:0] r_tgt_ip;
   logic        r_grat;

   logic        w_start;
   logic        w_grat;
   logic [47:0] w_start_dst;
   logic [31:0] w_start_tgt;
   logic [4:0]  w_cnt_nxt;

   // Word map; THA and oper differ between reply and gratuitous request.
   function automatic logic [31:0] f_word(input logic [4:0]  idx,
                                          input logic [47:0] d,
                                          input logic [47:0] s,
                                          input logic [31:0] p,
                                          input logic [31:0] t,
                                          input logic        grat);
      logic [47:0] tha;
      logic [15:0] oper;
      tha  = grat ? 48'h0 : d;
      oper = grat ? 16'h0001 : 16'h0002;
      case (idx)
         5'd0:    f_word = d[47:16];
         5'd1:    f_word = {d[15:0], s[47:32]};
         5'd2:    f_word = s[31:0];
         5'd3:    f_word = 32'h0806_0001;
         5'd4:    f_word = 32'h0800_0604;
         5'd5:    f_word = {oper, s[47:32]};
         5'd6:    f_word = s[31:0];
         5'd7:    f_word = p;
         5'd8:    f_word = tha[47:16];
         5'd9:    f_word = {tha[15:0], t[31:16]};
         5'd10:   f_word = {t[15:0], 16'h0};
         default: f_word = 32'h0;
      endcase
   endfunction

   always_comb begin
`ifdef ARP_TX_GRATUITOUS_EN
      // Reply wins if both requests arrive together.
      w_grat  = i_grat_req & ~i_arp_sync;
      w_start = i_arp_sync | i_grat_req;
`else
      w_grat  = 1'b0;
      w_start = i_arp_sync;
`endif
      w_start_dst = w_grat ? 48'hFFFF_FFFF_FFFF : i_req_mac;
      w_start_tgt = w_grat ? i_self_ip : i_req_ip;
   end

   assign w_cnt_nxt   = r_cnt + 5'd1;
   assign o_out_empty = 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= 5'd0;
         r_dst_mac   <= 48'h0;
         r_src_mac   <= 48'h0;
         r_src_ip    <= 32'h0;
         r_tgt_ip    <= 32'h0;
         r_grat      <= 1'b0;
         o_arp_ready <= 1'b1;
         o_out_vld   <= 1'b0;
         o_out_sop   <= 1'b0;
         o_out_eop   <= 1'b0;
         o_out_data  <= 32'h0;
      end else begin
         case (r_state)
            StIdle: begin
               o_arp_ready <= 1'b1;
               if (w_start) begin
                  r_dst_mac   <= w_start_dst;
                  r_src_mac   <= i_self_mac;
                  r_src_ip    <= i_self_ip;
                  r_tgt_ip    <= w_start_tgt;
                  r_grat      <= w_grat;
                  r_cnt       <= 5'd0;
                  r_state     <= StSend;
                  o_arp_ready <= 1'b0;
                  o_out_vld   <= 1'b1;
                  o_out_sop   <= 1'b1;
                  o_out_eop   <= 1'b0;
                  // Latches are loading this cycle, so word 0 comes from the inputs.
                  o_out_data  <= f_word(5'd0, w_start_dst, i_self_mac, i_self_ip,
                                        w_start_tgt, w_grat);
               end
            end
            StSend: begin
               if (i_out_rdy) begin
                  if (r_cnt == LastIdx) begin
                     r_state    <= StDone;
                     o_out_vld  <= 1'b0;
                     o_out_sop  <= 1'b0;
                     o_out_eop  <= 1'b0;
                     o_out_data <= 32'h0;
                  end else begin
                     r_cnt      <= w_cnt_nxt;
                     o_out_sop  <= 1'b0;
                     o_out_eop  <= (w_cnt_nxt == LastIdx);
                     o_out_data <= f_word(w_cnt_nxt, r_dst_mac, r_src_mac, r_src_ip,
                                          r_tgt_ip, r_grat);
                  end
               end
            end
            StDone: begin
               r_state     <= StIdle;
               o_arp_ready <= 1'b1;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_arp_tx.sv
// tb_eth_arp_tx: table-driven bench for eth_arp_tx (FRAME_WORDS = 15).
module tb_eth_arp_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_arp_sync = 1'b0;
`ifdef ARP_TX_GRATUITOUS_EN
   logic        i_grat_req = 1'b0;
`endif
   logic [47:0] i_self_mac = 48'h02_00_00_00_00_01;
   logic [31:0] i_self_ip  = 32'hC0A8_010A;
   logic [47:0] i_req_mac  = 48'h00_11_22_33_44_55;
   logic [31:0] i_req_ip   = 32'hC0A8_0164;
   logic        o_arp_ready;
   logic [31:0] o_out_data;
   logic        o_out_sop;
   logic        o_out_eop;
   logic        o_out_vld;
   logic [1:0]  o_out_empty;
   logic        i_out_rdy = 1'b1;

   always #5 clk = ~clk;

   eth_arp_tx #(.FRAME_WORDS(15)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_arp_sync  (i_arp_sync),
`ifdef ARP_TX_GRATUITOUS_EN
      .i_grat_req  (i_grat_req),
`endif
      .i_self_mac  (i_self_mac),
      .i_self_ip   (i_self_ip),
      .i_req_mac   (i_req_mac),
      .i_req_ip    (i_req_ip),
      .o_arp_ready (o_arp_ready),
      .o_out_data  (o_out_data),
      .o_out_sop   (o_out_sop),
      .o_out_eop   (o_out_eop),
      .o_out_vld   (o_out_vld),
      .o_out_empty (o_out_empty),
      .i_out_rdy   (i_out_rdy)
   );

   typedef struct {
      logic [31:0] word;
      logic        sop;
      logic        eop;
   } vec_t;

   vec_t        reply_tbl[15];
   vec_t        grat_tbl[15];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cap_data[$];
   logic        cap_sop[$];
   logic        cap_eop[$];
   int          ready_low;
   int          gaps;
   int          eop_cyc;
   bit          first_ok;
   bit          finished;
   logic [1:0]  empty_or;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Entered at the negedge right after the start pulse was sampled.
   // mode 0: rdy high; 1: 3-cycle stall on w4 plus random stalls; 2: sync at w6;
   // 3: change i_req_ip one cycle after sync; 4: return while w7 is presented.
   task automatic collect(input int mode);
      int          w4_hold = 3;
      bit          prev_stall = 1'b0;
      bit          clr_sync = 1'b0;
      bit          injected = 1'b0;
      bit          done = 1'b0;
      logic [31:0] prev_data = 32'h0;
      logic        prev_sop = 1'b0;
      logic        prev_eop = 1'b0;
      cap_data.delete();
      cap_sop.delete();
      cap_eop.delete();
      ready_low = 0;
      gaps      = 0;
      eop_cyc   = -1;
      finished  = 1'b0;
      empty_or  = 2'b00;
      first_ok  = (o_out_vld === 1'b1) && (o_out_sop === 1'b1);
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (clr_sync) begin
            i_arp_sync = 1'b0;
            clr_sync   = 1'b0;
         end
         if (done && o_arp_ready === 1'b1) begin
            finished = 1'b1;
            break;
         end
         if (o_arp_ready !== 1'b1) ready_low++;
         if (prev_stall) begin
            chk("hold_data", o_out_data, prev_data);
            chk("hold_sop", 32'(o_out_sop), 32'(prev_sop));
            chk("hold_eop", 32'(o_out_eop), 32'(prev_eop));
         end
         if (!done && o_out_vld !== 1'b1) gaps++;
         if (mode == 4 && o_out_vld && cap_data.size() == 7) return;
         if (mode == 3 && cyc == 0) i_req_ip = 32'h0A00_0001;
         if (mode == 2 && o_out_vld && cap_data.size() == 6 && !injected) begin
            i_arp_sync = 1'b1;
            i_req_mac  = 48'hAA_BB_CC_DD_EE_FF;
            injected   = 1'b1;
            clr_sync   = 1'b1;
         end
         if (mode == 1) begin
            if (o_out_vld && cap_data.size() == 4 && w4_hold > 0) begin
               i_out_rdy = 1'b0;
               w4_hold--;
            end else begin
               i_out_rdy = ($urandom_range(0, 3) != 0);
            end
         end else begin
            i_out_rdy = 1'b1;
         end
         if (!done && o_out_vld && i_out_rdy) begin
            cap_data.push_back(o_out_data);
            cap_sop.push_back(o_out_sop);
            cap_eop.push_back(o_out_eop);
            empty_or = empty_or | o_out_empty;
            if (o_out_eop) begin
               done    = 1'b1;
               eop_cyc = cyc;
            end
         end
         prev_stall = o_out_vld && !i_out_rdy;
         prev_data  = o_out_data;
         prev_sop   = o_out_sop;
         prev_eop   = o_out_eop;
         @(negedge clk);
      end
      i_out_rdy = 1'b1;
      if (!finished) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout mode=%0d words=%0d required=eop then ready", mode,
                  cap_data.size());
      end
   endtask

   task automatic check_frame(input bit grat);
      vec_t v;
      chk("word_count", 32'(cap_data.size()), 32'd15);
      chk("empty", 32'(empty_or), 32'd0);
      chk("vld_gaps", 32'(gaps), 32'd0);
      for (int i = 0; i < 15 && i < cap_data.size(); i++) begin
         v = grat ? grat_tbl[i] : reply_tbl[i];
         chk($sformatf("w%0d_data", i), cap_data[i], v.word);
         chk($sformatf("w%0d_sop", i), 32'(cap_sop[i]), 32'(v.sop));
         chk($sformatf("w%0d_eop", i), 32'(cap_eop[i]), 32'(v.eop));
      end
   endtask

   task automatic pulse_sync();
      i_arp_sync = 1'b1;
      @(negedge clk);
      i_arp_sync = 1'b0;
   endtask

   initial begin
      logic [31:0] rw[15] = '{32'h0011_2233, 32'h4455_0200, 32'h0000_0001, 32'h0806_0001,
                              32'h0800_0604, 32'h0002_0200, 32'h0000_0001, 32'hC0A8_010A,
                              32'h0011_2233, 32'h4455_C0A8, 32'h0164_0000, 32'h0,
                              32'h0, 32'h0, 32'h0};
      logic [31:0] gw[15] = '{32'hFFFF_FFFF, 32'hFFFF_0200, 32'h0000_0001, 32'h0806_0001,
                              32'h0800_0604, 32'h0001_0200, 32'h0000_0001, 32'hC0A8_010A,
                              32'h0000_0000, 32'h0000_C0A8, 32'h010A_0000, 32'h0,
                              32'h0, 32'h0, 32'h0};
      int extra;
      for (int i = 0; i < 15; i++) begin
         reply_tbl[i] = '{word: rw[i], sop: (i == 0), eop: (i == 14)};
         grat_tbl[i]  = '{word: gw[i], sop: (i == 0), eop: (i == 14)};
      end

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(o_arp_ready), 32'd1);
      chk("rst_vld", 32'(o_out_vld), 32'd0);
      chk("rst_sop", 32'(o_out_sop), 32'd0);
      chk("rst_eop", 32'(o_out_eop), 32'd0);
      chk("rst_data", o_out_data, 32'h0);
      chk("rst_empty", 32'(o_out_empty), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reply without backpressure: latency and ready timing
      pulse_sync();
      collect(0);
      chk("t1_first_sop", 32'(first_ok), 32'd1);
      chk("t1_ready_low", 32'(ready_low), 32'd16);
      chk("t1_eop_cycle", 32'(eop_cyc), 32'd14);
      check_frame(1'b0);

      // Backpressure
      repeat (2) @(negedge clk);
      pulse_sync();
      collect(1);
      check_frame(1'b0);

      // Sync while busy is ignored; no second frame follows
      repeat (2) @(negedge clk);
      pulse_sync();
      collect(2);
      check_frame(1'b0);
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_out_vld === 1'b1) extra++;
         @(negedge clk);
      end
      chk("t3_no_second_frame", 32'(extra), 32'd0);
      i_req_mac = 48'h00_11_22_33_44_55;

      // Address change after latch does not reach the frame
      repeat (2) @(negedge clk);
      pulse_sync();
      collect(3);
      check_frame(1'b0);
      i_req_ip = 32'hC0A8_0164;

      // Reset while w7 is presented
      repeat (2) @(negedge clk);
      pulse_sync();
      collect(4);
      chk("t5_reached_w7", 32'(cap_data.size()), 32'd7);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_vld", 32'(o_out_vld), 32'd0);
      chk("t5_rst_ready", 32'(o_arp_ready), 32'd1);
      chk("t5_rst_eop", 32'(o_out_eop), 32'd0);
      chk("t5_rst_data", o_out_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      pulse_sync();
      collect(0);
      chk("t5_ready_low", 32'(ready_low), 32'd16);
      check_frame(1'b0);

`ifdef ARP_TX_GRATUITOUS_EN
      // Gratuitous request
      repeat (2) @(negedge clk);
      i_grat_req = 1'b1;
      @(negedge clk);
      i_grat_req = 1'b0;
      collect(0);
      chk("grat_ready_low", 32'(ready_low), 32'd16);
      check_frame(1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
